// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by PC,
// with a two-stage tracker that carries each prediction to EX for training.
// Optional counters: define BP_STATS_EN to add the stat_branches/stat_mispredicts ports.
module branch_predictor #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_F,
  input  logic        branch_F,
  input  logic        stall_F,
  input  logic        stall_DE,
  input  logic        flush_DE,
  input  logic        flush_EX,
  input  logic        branch_EX,
  input  logic        branch_control,
  input  logic        branch_correction,
`ifdef BP_STATS_EN
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts,
`endif
  output logic        predict_taken_F,
  output logic        branch_decision
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            ctr_q [ENTRIES];
  logic [INDEX_BITS-1:0] idx_F;
  logic [1:0]            ctr_F;

  logic                  valid_DE, pred_DE;
  logic [INDEX_BITS-1:0] idx_DE;
  logic                  valid_EX, pred_EX;
  logic [INDEX_BITS-1:0] idx_EX;

  logic                  update;
  logic [1:0]            ctr_EX;
  logic [1:0]            ctr_next;

  // The fetch stage never stalls the tracker, and without the stats the
  // correction flag has no consumer; the low PC bits are below word alignment.
  logic unused_inputs;
  assign unused_inputs = ^{stall_F, branch_correction, pc_F[31:INDEX_BITS+2], pc_F[1:0]};

  assign idx_F           = pc_F[INDEX_BITS+1:2];
  assign ctr_F           = ctr_q[idx_F];
  assign predict_taken_F = branch_F & ctr_F[1];

  assign branch_decision = valid_EX & pred_EX;
  assign update          = branch_EX & valid_EX;

  assign ctr_EX = ctr_q[idx_EX];

  always_comb begin
    ctr_next = ctr_EX;
    if (branch_control) begin
      if (ctr_EX != 2'b11) ctr_next = ctr_EX + 2'b01;
    end else begin
      if (ctr_EX != 2'b00) ctr_next = ctr_EX - 2'b01;
    end
  end

  // Reset rewrites every entry, so it also overrides an update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (update) begin
      ctr_q[idx_EX] <= ctr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_DE <= 1'b0;
      pred_DE  <= 1'b0;
      idx_DE   <= '0;
    end else if (flush_DE) begin
      valid_DE <= 1'b0;
    end else if (!stall_DE) begin
      valid_DE <= branch_F;
      pred_DE  <= predict_taken_F;
      idx_DE   <= idx_F;
    end
  end

  // A held decode stage sends a bubble forward rather than duplicating its entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_EX <= 1'b0;
      pred_EX  <= 1'b0;
      idx_EX   <= '0;
    end else if (flush_EX || stall_DE) begin
      valid_EX <= 1'b0;
    end else begin
      valid_EX <= valid_DE;
      pred_EX  <= pred_DE;
      idx_EX   <= idx_DE;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (update) stat_branches <= stat_branches + 32'd1;
      if (valid_EX && branch_correction) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by random
// traffic, all compared against a table/record reference model kept here.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_F = 32'h0;
  logic        branch_F = 1'b0, stall_F = 1'b0, stall_DE = 1'b0, flush_DE = 1'b0;
  logic        flush_EX = 1'b0, branch_EX = 1'b0, branch_control = 1'b0;
  logic        branch_correction = 1'b0;
  logic        predict_taken_F, branch_decision;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int vectors = 0;
  int miscompares = 0;

  branch_predictor #(.INDEX_BITS(6)) dut (
    .clk(clk), .rst(rst), .pc_F(pc_F), .branch_F(branch_F), .stall_F(stall_F),
    .stall_DE(stall_DE), .flush_DE(flush_DE), .flush_EX(flush_EX),
    .branch_EX(branch_EX), .branch_control(branch_control),
    .branch_correction(branch_correction),
`ifdef BP_STATS_EN
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
`endif
    .predict_taken_F(predict_taken_F), .branch_decision(branch_decision)
  );

  always #5 clk = ~clk;

  // Reference model: counter values as plain integers 0..3, stages as records.
  typedef struct {bit v; bit p; int idx;} stage_t;
  int     m_tab [64];
  stage_t m_de, m_ex;
  bit     m_known = 1'b0;
  longint m_br_cnt, m_mp_cnt;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc, input logic br);
    return br && (m_tab[idx_of(pc)] >= 2);
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Let the inputs settle and compare the outputs against the model.
  task automatic check_now();
    #1;
    if (m_known) begin
      check_bit("predict_taken_F", predict_taken_F, m_pred(pc_F, branch_F));
      check_bit("branch_decision", branch_decision, m_ex.v && m_ex.p);
`ifdef BP_STATS_EN
      check_word("stat_branches", stat_branches, 32'(m_br_cnt));
      check_word("stat_mispredicts", stat_mispredicts, 32'(m_mp_cnt));
`endif
    end
  endtask

  // Advance one clock, updating the model from the inputs held across the edge.
  task automatic clock_it();
    stage_t f_rec;
    @(posedge clk);
    f_rec.v = branch_F; f_rec.p = m_pred(pc_F, branch_F); f_rec.idx = idx_of(pc_F);
    if (rst) begin
      foreach (m_tab[i]) m_tab[i] = 1;
      m_de.v = 0; m_ex.v = 0;
      m_br_cnt = 0; m_mp_cnt = 0;
      m_known = 1'b1;
    end else begin
      if (branch_EX && m_ex.v) begin
        m_br_cnt++;
        if (branch_control) m_tab[m_ex.idx] = (m_tab[m_ex.idx] == 3) ? 3 : m_tab[m_ex.idx] + 1;
        else                m_tab[m_ex.idx] = (m_tab[m_ex.idx] == 0) ? 0 : m_tab[m_ex.idx] - 1;
      end
      if (m_ex.v && branch_correction) m_mp_cnt++;
      if (flush_EX || stall_DE) m_ex.v = 0;
      else                      m_ex = m_de;
      if (flush_DE)       m_de.v = 0;
      else if (!stall_DE) m_de = f_rec;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] pc, input logic br, input logic bex,
                       input logic bc, input logic fde, input logic sde);
    pc_F = pc; branch_F = br; branch_EX = bex; branch_control = bc;
    flush_DE = fde; stall_DE = sde;
    stall_F = 1'b0; flush_EX = 1'b0; branch_correction = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    drive(32'h0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    check_now(); clock_it();
    check_now(); clock_it();
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Reset state, then train 0x40 taken while fetching it every cycle.
    drive(32'h40, 1, 1, 1, 0, 0); check_now();
    check_bit("reset_pred_0x40", predict_taken_F, 1'b0);
    check_bit("reset_decision", branch_decision, 1'b0);
    clock_it();
    check_now(); clock_it();
    check_now();
    check_bit("same_cycle_no_bypass", predict_taken_F, 1'b0);
    clock_it();                                       // 01 -> 10
    check_now();
    check_bit("trained_weak_taken", predict_taken_F, 1'b1);
    clock_it();                                       // 10 -> 11
    check_now(); clock_it();                          // third taken: stays 11
    drive(32'h140, 1, 1, 0, 0, 0); check_now();
    check_bit("alias_0x140_taken", predict_taken_F, 1'b1);
    check_bit("decision_taken", branch_decision, 1'b1);
    clock_it();                                       // 11 -> 10 (trained via alias)
    drive(32'h40, 1, 1, 0, 0, 0);
    check_now(); clock_it();                          // 10 -> 01
    check_now();
    check_bit("untrained_to_nt", predict_taken_F, 1'b0);
    clock_it();                                       // 01 -> 00
    check_now(); clock_it();                          // 00 stays 00
    drive(32'h40, 1, 1, 1, 0, 0); check_now();
    check_bit("saturate_at_00", predict_taken_F, 1'b0);
    clock_it();                                       // 00 -> 01
    check_now();
    check_bit("after_sat_01", predict_taken_F, 1'b0);
    clock_it();                                       // 01 -> 10

    // Predicted-taken branch killed on its way into DE.
    drive(32'h40, 1, 0, 0, 1, 0); check_now();
    check_bit("flush_src_pred", predict_taken_F, 1'b1);
    clock_it();
    drive(32'h0, 0, 0, 0, 0, 0); check_now(); clock_it();
    drive(32'h0, 0, 1, 0, 0, 0); check_now();
    check_bit("flushed_decision", branch_decision, 1'b0);
    clock_it();
    drive(32'h40, 1, 0, 0, 0, 0); check_now();
    check_bit("flush_no_update", predict_taken_F, 1'b1);
    clock_it();

    // Decode held two cycles: EX sees bubbles, then the held entry.
    drive(32'h0, 0, 0, 0, 0, 1); check_now(); clock_it();
    check_now(); clock_it();
    check_bit("stall_bubble_1", branch_decision, 1'b0);
    drive(32'h0, 0, 0, 0, 0, 0); check_now();
    check_bit("stall_bubble_2", branch_decision, 1'b0);
    clock_it();
    check_now();
    check_bit("stall_held_entry", branch_decision, 1'b1);
    clock_it();

    // Reset arriving together with an increment wins.
    drive(32'h40, 1, 1, 1, 0, 0);
    rst = 1'b1; check_now(); clock_it();
    drive(32'h40, 1, 0, 0, 0, 0); check_now();
    check_bit("reset_wins_update", predict_taken_F, 1'b0);
    clock_it();

`ifdef BP_STATS_EN
    do_reset();
    drive(32'h80, 1, 0, 0, 0, 0); check_now(); clock_it();
    check_now(); clock_it();
    drive(32'h80, 1, 1, 1, 0, 0); check_now(); clock_it();
    drive(32'h0, 0, 1, 0, 0, 0); branch_correction = 1'b1; check_now(); clock_it();
    drive(32'h0, 0, 1, 1, 0, 0); check_now(); clock_it();
    drive(32'h0, 0, 0, 0, 0, 0); check_now();
    check_word("stats_branches_3", stat_branches, 32'd3);
    check_word("stats_mispredicts_1", stat_mispredicts, 32'd1);
    clock_it();
`endif

    // Random traffic on a few contended indices.
    for (int n = 0; n < 800; n++) begin
      int sel;
      int idxs [4];
      idxs = '{16, 17, 5, 63};
      sel = int'($urandom_range(0, 3));
      pc_F              = ($urandom & 32'hFFFF_FF00) | 32'(idxs[sel] << 2) | ($urandom & 32'h3);
      branch_F          = ($urandom % 4) != 0;
      stall_F           = ($urandom % 5) == 0;
      stall_DE          = ($urandom % 6) == 0;
      flush_DE          = ($urandom % 8) == 0;
      flush_EX          = ($urandom % 8) == 0;
      branch_EX         = m_ex.v ? (($urandom % 8) != 0) : ($urandom % 2 == 1);
      branch_control    = $urandom % 2 == 1;
      branch_correction = $urandom % 3 == 0;
      rst               = ($urandom % 97) == 0;
      check_now();
      clock_it();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
